// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: hazard detection, exception
// flush, mult/div sequencing with a watchdog, and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int DELAY_SLOT = 1,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_rs_D,
  input  logic [4:0]       i_rt_D,
  input  logic             i_use_rs_D,
  input  logic             i_use_rt_D,
  input  logic             i_branch_D,
  input  logic             i_redirect_D,
  input  logic             i_memread_E,
  input  logic             i_regwrite_E,
  input  logic [4:0]       i_writereg_E,
  input  logic             i_memread_M,
  input  logic             i_regwrite_M,
  input  logic [4:0]       i_writereg_M,
  input  logic             i_md_start_E,
  input  logic             i_md_ready,
  input  logic             i_exc_M,
  output logic             o_en_F,
  output logic             o_en_D,
  output logic             o_en_E,
  output logic             o_en_M,
  output logic             o_en_W,
  output logic             o_clr_D,
  output logic             o_clr_E,
  output logic             o_clr_M,
  output logic             o_md_go,
  output logic             o_md_err,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam int WD_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MD_TIMEOUT);

  typedef enum logic [0:0] {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

  md_state_t         r_state;
  md_state_t         w_state_nxt;
  logic [WD_W-1:0]   r_wd;
  logic [WD_W-1:0]   w_wd_nxt;
  logic              w_err_set;
  logic              w_match_e_rs, w_match_e_rt, w_match_m_rs, w_match_m_rt;
  logic              w_lu, w_br, w_stall_D, w_md_active;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_md_err;
  logic              w_unused;

  // M-stage regwrite plays no part in any hazard term
  assign w_unused = i_regwrite_M;

  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src == dst) && (src != 5'd0);
  endfunction

  assign w_match_e_rs = reg_match(i_rs_D, i_writereg_E);
  assign w_match_e_rt = reg_match(i_rt_D, i_writereg_E);
  assign w_match_m_rs = reg_match(i_rs_D, i_writereg_M);
  assign w_match_m_rt = reg_match(i_rt_D, i_writereg_M);

  assign w_lu = i_memread_E & i_regwrite_E &
                ((i_use_rs_D & w_match_e_rs) | (i_use_rt_D & w_match_e_rt));
  assign w_br = i_branch_D &
                ((i_regwrite_E & (w_match_e_rs | w_match_e_rt)) |
                 (i_memread_M  & (w_match_m_rs | w_match_m_rt)));
  assign w_stall_D = w_lu | w_br;

  assign w_md_active = ((r_state == MD_IDLE) & i_md_start_E) |
                       ((r_state == MD_BUSY) & ~i_md_ready & (r_wd < WD_LIMIT));

  // mult/div next state and watchdog; exception aborts, timeout acts as ready
  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = r_wd;
    w_err_set   = 1'b0;
    if (i_exc_M) begin
      w_state_nxt = MD_IDLE;
      w_wd_nxt    = '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_md_start_E) begin
            w_state_nxt = MD_BUSY;
            w_wd_nxt    = '0;
          end else begin
            w_state_nxt = MD_IDLE;
          end
        end
        MD_BUSY: begin
          if (i_md_ready) begin
            w_state_nxt = MD_IDLE;
            w_wd_nxt    = '0;
          end else if (r_wd >= WD_LIMIT) begin
            w_state_nxt = MD_IDLE;
            w_wd_nxt    = '0;
            w_err_set   = 1'b1;
          end else begin
            w_wd_nxt    = r_wd + WD_W'(1);
          end
        end
        default: begin
          w_state_nxt = MD_IDLE;
          w_wd_nxt    = '0;
        end
      endcase
    end
  end

  // enable/clear priority: exception, mult/div freeze, D stall, redirect flush
  always_comb begin
    o_en_F  = 1'b1;
    o_en_D  = 1'b1;
    o_en_E  = 1'b1;
    o_en_M  = 1'b1;
    o_en_W  = 1'b1;
    o_clr_D = 1'b0;
    o_clr_E = 1'b0;
    o_clr_M = 1'b0;
    o_md_go = 1'b0;
    if (rst) begin
      o_md_go = 1'b0;
    end else if (i_exc_M) begin
      o_clr_D = 1'b1;
      o_clr_E = 1'b1;
      o_clr_M = 1'b1;
    end else if (w_md_active) begin
      o_en_F  = 1'b0;
      o_en_D  = 1'b0;
      o_en_E  = 1'b0;
      o_clr_M = 1'b1;
      o_md_go = (r_state == MD_IDLE);
    end else if (w_stall_D) begin
      o_en_F  = 1'b0;
      o_en_D  = 1'b0;
      o_clr_E = 1'b1;
    end else if (i_redirect_D && (DELAY_SLOT == 0)) begin
      o_clr_D = 1'b1;
    end else begin
      o_clr_D = 1'b0;
    end
  end

  // FSM state, watchdog and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MD_IDLE;
      r_wd     <= '0;
      r_md_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wd     <= w_wd_nxt;
      r_md_err <= r_md_err | w_err_set;
    end
  end

  // saturating count of fetch-stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!o_en_F && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign o_md_err       = r_md_err;
  assign o_stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a cycle-level
// behavioural model of the hazard/flush rules.
module tb_pipe_hazard_ctrl;
  localparam int CW = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs_D, rt_D, writereg_E, writereg_M;
  logic use_rs_D, use_rt_D, branch_D, redirect_D;
  logic memread_E, regwrite_E, memread_M, regwrite_M;
  logic md_start_E, md_ready, exc_M;
  logic en_F, en_D, en_E, en_M, en_W, clr_D, clr_E, clr_M, md_go, md_err;
  logic [CW-1:0] stall_cycles;
  logic [8:0] dut_vec;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit m_busy;
  int m_wd;
  bit m_err;
  int m_stall;

  pipe_hazard_ctrl #(.DELAY_SLOT(0), .MD_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_rs_D(rs_D), .i_rt_D(rt_D), .i_use_rs_D(use_rs_D), .i_use_rt_D(use_rt_D),
    .i_branch_D(branch_D), .i_redirect_D(redirect_D),
    .i_memread_E(memread_E), .i_regwrite_E(regwrite_E), .i_writereg_E(writereg_E),
    .i_memread_M(memread_M), .i_regwrite_M(regwrite_M), .i_writereg_M(writereg_M),
    .i_md_start_E(md_start_E), .i_md_ready(md_ready), .i_exc_M(exc_M),
    .o_en_F(en_F), .o_en_D(en_D), .o_en_E(en_E), .o_en_M(en_M), .o_en_W(en_W),
    .o_clr_D(clr_D), .o_clr_E(clr_E), .o_clr_M(clr_M),
    .o_md_go(md_go), .o_md_err(md_err), .o_stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign dut_vec = {en_F, en_D, en_E, en_M, en_W, clr_D, clr_E, clr_M, md_go};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit hit(input logic [4:0] r, input logic [4:0] w);
    return (r == w) && (r != 5'd0);
  endfunction

  // expected {en_F,en_D,en_E,en_M,en_W,clr_D,clr_E,clr_M,md_go}
  function automatic logic [8:0] model_out();
    bit lu, br, active;
    lu = memread_E && regwrite_E &&
         ((use_rs_D && hit(rs_D, writereg_E)) || (use_rt_D && hit(rt_D, writereg_E)));
    br = branch_D && ((regwrite_E && (hit(rs_D, writereg_E) || hit(rt_D, writereg_E))) ||
                      (memread_M && (hit(rs_D, writereg_M) || hit(rt_D, writereg_M))));
    active = (!m_busy && md_start_E) || (m_busy && !md_ready && m_wd < TO);
    if (exc_M)           return 9'b11111_111_0;
    else if (active)     return {8'b00011_001, !m_busy};
    else if (lu || br)   return 9'b00111_010_0;
    else if (redirect_D) return 9'b11111_100_0;
    else                 return 9'b11111_000_0;
  endfunction

  task automatic model_step(input logic [8:0] e);
    if (e[8] == 1'b0 && m_stall < (1 << CW) - 1) m_stall++;
    if (exc_M) begin
      m_busy = 0; m_wd = 0;
    end else if (!m_busy) begin
      if (md_start_E) begin m_busy = 1; m_wd = 0; end
    end else if (md_ready) begin
      m_busy = 0;
    end else if (m_wd >= TO) begin
      m_busy = 0; m_err = 1;
    end else begin
      m_wd++;
    end
  endtask

  task automatic idle_inputs();
    rs_D = 5'd0; rt_D = 5'd0; writereg_E = 5'd0; writereg_M = 5'd0;
    use_rs_D = 1'b0; use_rt_D = 1'b0; branch_D = 1'b0; redirect_D = 1'b0;
    memread_E = 1'b0; regwrite_E = 1'b0; memread_M = 1'b0; regwrite_M = 1'b0;
    md_start_E = 1'b0; md_ready = 1'b0; exc_M = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_busy = 0; m_wd = 0; m_err = 0; m_stall = 0;
  endtask

  // one clock: compare against the model mid-cycle, then advance the model
  task automatic step(input string tag);
    logic [8:0] e;
    @(negedge clk);
    e = model_out();
    check_val({tag, " ctl"}, {23'd0, dut_vec}, {23'd0, e});
    check_val({tag, " stall"}, {24'd0, stall_cycles}, 32'(m_stall));
    check_val({tag, " err"}, {31'd0, md_err}, {31'd0, m_err});
    model_step(e);
    @(posedge clk); #1;
  endtask

  task automatic look(input string tag, input logic [8:0] e);
    #1;
    check_val(tag, {23'd0, dut_vec}, {23'd0, e});
  endtask

  initial begin
    // reset: defaults forced even with hazards present
    idle_inputs();
    rst = 1'b1;
    md_start_E = 1'b1; memread_E = 1'b1; regwrite_E = 1'b1; writereg_E = 5'd5;
    rs_D = 5'd5; use_rs_D = 1'b1; exc_M = 1'b1;
    #3;
    check_val("rst ctl", {23'd0, dut_vec}, 32'h1F0);
    check_val("rst stall", {24'd0, stall_cycles}, 32'd0);
    check_val("rst err", {31'd0, md_err}, 32'd0);
    @(posedge clk);
    do_reset();

    // load-use
    memread_E = 1'b1; regwrite_E = 1'b1; writereg_E = 5'd5; rs_D = 5'd5; use_rs_D = 1'b1;
    look("lu ctl", 9'b00111_010_0);
    step("lu");
    check_val("lu stall cnt", {24'd0, stall_cycles}, 32'd1);
    // register 0 never matches
    writereg_E = 5'd0; rs_D = 5'd0;
    look("reg0 ctl", 9'b11111_000_0);
    step("reg0");

    // branch hazard with redirect suppressed, then flush next cycle
    do_reset();
    branch_D = 1'b1; rt_D = 5'd3; use_rt_D = 1'b1; memread_M = 1'b1; writereg_M = 5'd3;
    redirect_D = 1'b1;
    look("br ctl", 9'b00111_010_0);
    step("br");
    memread_M = 1'b0;
    look("br redirect", 9'b11111_100_0);
    step("br2");

    // mult/div with ready at cycle 5
    do_reset();
    md_start_E = 1'b1;
    look("md go", 9'b00011_001_1);
    step("md0");
    for (int c = 1; c < 5; c++) begin
      look("md frozen", 9'b00011_001_0);
      step("md busy");
    end
    md_ready = 1'b1;
    look("md release", 9'b11111_000_0);
    step("md5");
    md_start_E = 1'b0; md_ready = 1'b0;
    look("md idle", 9'b11111_000_0);
    check_val("md stall cnt", {24'd0, stall_cycles}, 32'd5);
    step("md6");

    // watchdog timeout
    do_reset();
    md_start_E = 1'b1;
    look("to go", 9'b00011_001_1);
    step("to0");
    for (int c = 1; c < 5; c++) begin
      look("to frozen", 9'b00011_001_0);
      step("to busy");
    end
    look("to release", 9'b11111_000_0);
    step("to5");
    check_val("to err set", {31'd0, md_err}, 32'd1);
    look("to fresh go", 9'b00011_001_1);
    step("to6");
    md_ready = 1'b1;
    look("to ready", 9'b11111_000_0);
    step("to7");
    md_start_E = 1'b0; md_ready = 1'b0;
    step("to8");
    check_val("to err sticky", {31'd0, md_err}, 32'd1);

    // exception aborts BUSY; late ready ignored
    do_reset();
    md_start_E = 1'b1;
    step("ex0");
    step("ex1");
    exc_M = 1'b1;
    look("ex flush", 9'b11111_111_0);
    step("ex2");
    exc_M = 1'b0; md_start_E = 1'b0; md_ready = 1'b1;
    look("ex late ready", 9'b11111_000_0);
    step("ex3");

    // async reset in the middle of BUSY
    md_ready = 1'b0; md_start_E = 1'b1;
    step("ar0");
    step("ar1");
    rst = 1'b1;
    look("ar ctl", 9'b11111_000_0);
    check_val("ar stall", {24'd0, stall_cycles}, 32'd0);
    do_reset();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
      writereg_E = 5'($urandom_range(0, 3)); writereg_M = 5'($urandom_range(0, 3));
      use_rs_D = 1'($urandom); use_rt_D = 1'($urandom);
      branch_D = ($urandom_range(0, 3) == 0); redirect_D = ($urandom_range(0, 3) == 0);
      memread_E = 1'($urandom); regwrite_E = 1'($urandom);
      memread_M = 1'($urandom); regwrite_M = 1'($urandom);
      md_start_E = ($urandom_range(0, 5) == 0);
      md_ready = ($urandom_range(0, 6) == 0);
      exc_M = ($urandom_range(0, 24) == 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the enable/clear pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and sequences the multi-cycle mult/div unit.
- Detects load-use and branch-operand hazards, handles exceptions, and counts stall cycles.
- Pipeline registers honour clear only when enable is also high, so every flush this block requests drives clr_X=1 together with en_X=1.

Parameters:
DELAY_SLOT, 1, 1: instruction after a taken branch/jump executes; 0: it is flushed from D.
MD_TIMEOUT, 64, cycles in MD_BUSY before forced release and md_err (>=2).
CNT_W, 32, width of stall cycle counter.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rs_D, rt_D  in  5  source regs of instruction in D
use_rs_D, use_rt_D  in  1  D actually reads rs / rt
branch_D  in  1  D holds a branch that compares registers in D
redirect_D  in  1  branch taken / jump in D
memread_E, regwrite_E  in  1  E-stage control
writereg_E  in  5  E destination
memread_M, regwrite_M  in  1  M-stage control
writereg_M  in  5  M destination
md_start_E  in  1  E holds mult/div
md_ready  in  1  mult/div result valid (1-cycle pulse)
exc_M  in  1  exception committed at M
en_F, en_D, en_E, en_M, en_W  out  1  stage enables (PC reg = F)
clr_D, clr_E, clr_M  out  1  stage clears
md_go  out  1  start pulse to mult/div unit
md_err  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with en_F=0

Behaviour:
- Reset (async): state=MD_IDLE, wd counter=0, md_err=0, stall_cycles=0.
- While rst is high the combinational outputs take their defaults: all en=1, all clr=0, md_go=0.
- Hazard terms (combinational); regnum 0 never matches:
  - match_E(r) = r==writereg_E & r!=0; match_M likewise with writereg_M.
  - lu = memread_E & regwrite_E & ((use_rs_D & match_E(rs_D)) | (use_rt_D & match_E(rt_D))).
  - br = branch_D & ((regwrite_E & (match_E(rs_D)|match_E(rt_D))) | (memread_M & (match_M(rs_D)|match_M(rt_D)))).
  - stall_D = lu|br.
- Output priority, highest first; only one rule applies per cycle:
  1. exc_M:
     - en_F..en_W=1; clr_D=clr_E=clr_M=1; md_go=0.
     - FSM -> MD_IDLE; wd counter cleared.
  2. md_active = (MD_IDLE & md_start_E) | (MD_BUSY & !md_ready & wd<MD_TIMEOUT):
     - en_F=en_D=en_E=0.
     - en_M=1, clr_M=1 (bubble into M); en_W=1.
  3. stall_D:
     - en_F=en_D=0.
     - en_E=1, clr_E=1 (bubble into E).
     - en_M=en_W=1.
     - redirect_D is ignored this cycle.
  4. redirect_D & DELAY_SLOT==0: all en=1, clr_D=1.
  5. otherwise: all en=1, all clr=0.
- Mult/div FSM (MD_IDLE, MD_BUSY):
  - MD_IDLE, md_start_E & !exc_M:
    - md_go=1 for exactly this cycle (combinational); -> MD_BUSY; wd=0.
    - Pipeline frozen per rule 2.
  - MD_BUSY, each cycle: wd++.
  - md_ready=1:
    - This cycle unfreezes: all en=1, clr=0, unless rule 3/4 applies.
    - E advances at the edge; -> MD_IDLE.
    - No retrigger, since E holds the next instruction afterwards.
  - wd reaches MD_TIMEOUT: treat as md_ready (release, -> MD_IDLE) and set md_err=1 (sticky until rst).
  - md_ready in MD_IDLE is ignored.
  - md_ready in the md_go cycle is ignored; the unit latency is >=1 cycle.
  - exc_M in MD_BUSY aborts to MD_IDLE; the late md_ready is then ignored.
- stall_cycles: +1 on each clk edge where en_F==0; holds at all-ones.

Test Plan:
- Load-use: lw $5 in E (memread_E=1, regwrite_E=1, writereg_E=5), D uses rs_D=5 -> en_F=en_D=0, en_E=1, clr_E=1 for 1 cycle; stall_cycles 0->1.
- Reg-0 guard: same as the load-use case but writereg_E=0, rs_D=0 -> no stall; all en=1, clr=0.
- Branch hazard: branch_D=1, rt_D=3, memread_M=1, writereg_M=3 -> 1-cycle stall (en_F=0, clr_E=1); redirect_D=1 with DELAY_SLOT=0 -> clr_D not asserted that cycle, asserted the next cycle once the stall clears.
- Mult/div: md_start_E=1 at cycle 0, md_ready pulsed at cycle 5:
  - md_go=1 only at cycle 0.
  - en_E=0 and clr_M=1 during cycles 0-4; all en=1 at cycle 5; FSM idle at cycle 6.
  - stall_cycles=5.
- Timeout (MD_TIMEOUT=4), md_ready never asserted -> release at wd==4; md_err=1 and stays 1; the next md_start_E gives a fresh md_go.
- Exception: exc_M=1 in cycle 2 of MD_BUSY -> clr_D=clr_E=clr_M=1 with all en=1 in that cycle; FSM -> MD_IDLE; md_ready at cycle 3 is ignored. Async rst mid-BUSY -> outputs return to defaults immediately.
